// File: rtl/receive_scheduler.sv
// Receive scheduler: matches RECV/AVAIL requests against an age-ordered buffer of
// incoming network messages and hands the result to writeback.
module receive_scheduler #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned BUFFER_DEPTH = 4,
   parameter int unsigned PT_WIDTH     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         receive_queue_receive_scheduler_valid,
   output logic                         receive_scheduler_receive_queue_ready,
   input  logic [1+2*XLEN+PT_WIDTH-1:0] receive_queue_receive_scheduler_data,
   input  logic                         network_receive_scheduler_valid,
   output logic                         receive_scheduler_network_ready,
   input  logic [2*XLEN-1:0]            network_receive_scheduler_data,
   output logic                         receive_scheduler_writeback_valid,
   input  logic                         writeback_receive_scheduler_ready,
   output logic [XLEN+PT_WIDTH-1:0]     receive_scheduler_writeback_data
);

   localparam int unsigned IdxW = $clog2(BUFFER_DEPTH);
   localparam int unsigned CntW = $clog2(BUFFER_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StMatch, StWait, StWriteback} state_e;

   state_e                state_q, state_d;
   logic [XLEN-1:0]       meta_q [BUFFER_DEPTH];
   logic [XLEN-1:0]       data_q [BUFFER_DEPTH];
   logic [XLEN-1:0]       meta_d [BUFFER_DEPTH];
   logic [XLEN-1:0]       data_d [BUFFER_DEPTH];
   logic [CntW-1:0]       count_q, count_d;
   logic                  req_avail_q;
   logic [XLEN-1:0]       req_meta_q, req_mask_q;
   logic [PT_WIDTH-1:0]   req_pt_q;
   logic [XLEN-1:0]       result_q, result_d;

   logic                  req_hs, net_hs, remove;
   logic [BUFFER_DEPTH-1:0] match;
   logic                  any_match;
   logic [IdxW-1:0]       match_idx;
   logic [CntW-1:0]       ins_pos;
   logic [XLEN-1:0]       net_meta, net_data;

   assign net_meta = network_receive_scheduler_data[2*XLEN-1:XLEN];
   assign net_data = network_receive_scheduler_data[XLEN-1:0];

   assign receive_scheduler_receive_queue_ready = (state_q == StIdle);
   assign receive_scheduler_network_ready       = (count_q < CntW'(BUFFER_DEPTH));
   assign receive_scheduler_writeback_valid     = (state_q == StWriteback);
   assign receive_scheduler_writeback_data      = {result_q, req_pt_q};

   assign req_hs = receive_queue_receive_scheduler_valid && (state_q == StIdle);
   assign net_hs = network_receive_scheduler_valid && receive_scheduler_network_ready;

   // Match against registered contents only; same-cycle inserts are not visible.
   always_comb begin
      match     = '0;
      match_idx = '0;
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
         match[i] = (CntW'(i) < count_q) &&
                    (((meta_q[i] ^ req_meta_q) & req_mask_q) == '0);
      end
      for (int i = int'(BUFFER_DEPTH) - 1; i >= 0; i--) begin
         if (match[i]) match_idx = IdxW'(i);
      end
      any_match = |match;
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      remove   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (receive_queue_receive_scheduler_valid) state_d = StMatch;
         end
         StMatch: begin
            if (req_avail_q) begin
               result_d = {{(XLEN-1){1'b0}}, any_match};
               state_d  = StWriteback;
            end else if (any_match) begin
               result_d = data_q[match_idx];
               remove   = 1'b1;
               state_d  = StWriteback;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (net_hs) state_d = StMatch;
         end
         StWriteback: begin
            if (writeback_receive_scheduler_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Compact first, then append the incoming message behind the surviving entries.
   always_comb begin
      meta_d  = meta_q;
      data_d  = data_q;
      count_d = count_q;
      ins_pos = count_q;
      if (remove) begin
         for (int i = 0; i < int'(BUFFER_DEPTH) - 1; i++) begin
            if (IdxW'(i) >= match_idx) begin
               meta_d[i] = meta_q[i+1];
               data_d[i] = data_q[i+1];
            end
         end
         ins_pos = count_q - CntW'(1);
         count_d = count_q - CntW'(1);
      end
      if (net_hs) begin
         for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
            if (CntW'(i) == ins_pos) begin
               meta_d[i] = net_meta;
               data_d[i] = net_data;
            end
         end
         count_d = count_d + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         count_q     <= '0;
         req_avail_q <= 1'b0;
         req_meta_q  <= '0;
         req_mask_q  <= '0;
         req_pt_q    <= '0;
         result_q    <= '0;
         for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
            meta_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         result_q <= result_d;
         meta_q   <= meta_d;
         data_q   <= data_d;
         if (req_hs) begin
            {req_avail_q, req_meta_q, req_mask_q, req_pt_q} <=
               receive_queue_receive_scheduler_data;
         end
      end
   end

endmodule

// File: tb/tb_receive_scheduler.sv
// Directed bench for receive_scheduler: matching, ordering, waiting, backpressure and reset.
module tb_receive_scheduler;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BUFFER_DEPTH = 4;
   localparam int unsigned PT_WIDTH = 8;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         rq_valid;
   logic                         rq_ready;
   logic [1+2*XLEN+PT_WIDTH-1:0] rq_data;
   logic                         net_valid;
   logic                         net_ready;
   logic [2*XLEN-1:0]            net_data;
   logic                         wb_valid;
   logic                         wb_ready;
   logic [XLEN+PT_WIDTH-1:0]     wb_data;

   int vectors = 0;
   int miscompares = 0;

   receive_scheduler #(
      .XLEN(XLEN),
      .BUFFER_DEPTH(BUFFER_DEPTH),
      .PT_WIDTH(PT_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .receive_queue_receive_scheduler_valid(rq_valid),
      .receive_scheduler_receive_queue_ready(rq_ready),
      .receive_queue_receive_scheduler_data(rq_data),
      .network_receive_scheduler_valid(net_valid),
      .receive_scheduler_network_ready(net_ready),
      .network_receive_scheduler_data(net_data),
      .receive_scheduler_writeback_valid(wb_valid),
      .writeback_receive_scheduler_ready(wb_ready),
      .receive_scheduler_writeback_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_msg(input logic [31:0] meta, input logic [31:0] data);
      net_valid = 1'b1;
      net_data  = {meta, data};
      tick();
      net_valid = 1'b0;
   endtask

   // Request handshake happens at the edge inside this task; returns in the MATCH cycle.
   task automatic issue(input logic avail, input logic [31:0] meta, input logic [31:0] mask,
                        input logic [7:0] pt);
      rq_valid = 1'b1;
      rq_data  = {avail, meta, mask, pt};
      tick();
      rq_valid = 1'b0;
   endtask

   task automatic drain();
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rq_valid = 1'b0; rq_data = '0;
      net_valid = 1'b0; net_data = '0; wb_ready = 1'b0;
      tick();
      rst = 1'b0;
      check("reset_rq_ready", 64'(rq_ready), 64'd1);
      check("reset_net_ready", 64'(net_ready), 64'd1);
      check("reset_wb_valid", 64'(wb_valid), 64'd0);
      check("reset_wb_data", 64'(wb_data), 64'd0);

      // Exact match removes the younger entry, older one shifts nowhere.
      push_msg(32'h10, 32'hA);
      push_msg(32'h20, 32'hB);
      check("two_inserted_count", 64'(dut.count_q), 64'd2);
      issue(1'b0, 32'h20, 32'hFFFF_FFFF, 8'h5A);
      check("match_cycle_no_valid", 64'(wb_valid), 64'd0);
      check("match_cycle_rq_ready", 64'(rq_ready), 64'd0);
      tick();
      check("recv_exact_valid", 64'(wb_valid), 64'd1);
      check("recv_exact_data", 64'(wb_data), 64'h0B_5A);
      check("recv_exact_count", 64'(dut.count_q), 64'd1);
      check("recv_exact_e0_meta", 64'(dut.meta_q[0]), 64'h10);
      check("recv_exact_e0_data", 64'(dut.data_q[0]), 64'hA);
      drain();
      check("after_wb_idle", 64'(rq_ready), 64'd1);

      // Masked match: oldest wins, then the next one.
      do_reset();
      push_msg(32'h11, 32'h1);
      push_msg(32'h12, 32'h2);
      issue(1'b0, 32'h10, 32'hFFFF_FFF0, 8'h01);
      tick();
      check("masked_first_data", 64'(wb_data), 64'h1_01);
      drain();
      issue(1'b0, 32'h10, 32'hFFFF_FFF0, 8'h02);
      tick();
      check("masked_second_data", 64'(wb_data), 64'h2_02);
      check("masked_empty_count", 64'(dut.count_q), 64'd0);
      drain();

      // RECV on empty buffer waits for the network.
      issue(1'b0, 32'h5, 32'hFFFF_FFFF, 8'hC3);
      tick();
      tick();
      tick();
      check("wait_no_valid", 64'(wb_valid), 64'd0);
      check("wait_rq_ready", 64'(rq_ready), 64'd0);
      push_msg(32'h5, 32'h77);
      check("wait_e1_no_valid", 64'(wb_valid), 64'd0);
      tick();
      check("wait_e2_valid", 64'(wb_valid), 64'd1);
      check("wait_e2_data", 64'(wb_data), 64'h77_C3);
      check("wait_consumed_count", 64'(dut.count_q), 64'd0);
      drain();

      // AVAIL leaves the buffer alone.
      push_msg(32'h3, 32'h33);
      issue(1'b1, 32'h3, 32'hFFFF_FFFF, 8'h11);
      tick();
      check("avail_hit_data", 64'(wb_data), 64'h1_11);
      check("avail_hit_count", 64'(dut.count_q), 64'd1);
      drain();
      issue(1'b1, 32'h4, 32'hFFFF_FFFF, 8'h22);
      tick();
      check("avail_miss_data", 64'(wb_data), 64'h0_22);
      drain();
      issue(1'b1, 32'hDEAD, 32'h0, 8'h33);
      tick();
      check("avail_mask0_data", 64'(wb_data), 64'h1_33);
      drain();

      // Full buffer: removal frees the last slot for a held network message.
      push_msg(32'h40, 32'h400);
      push_msg(32'h41, 32'h401);
      push_msg(32'h42, 32'h402);
      check("full_count", 64'(dut.count_q), 64'd4);
      check("full_net_ready", 64'(net_ready), 64'd0);
      net_valid = 1'b1;
      net_data  = {32'h50, 32'h500};
      issue(1'b0, 32'h40, 32'hFFFF_FFFF, 8'h77);
      check("full_match_net_ready", 64'(net_ready), 64'd0);
      tick();
      check("full_post_match_net_ready", 64'(net_ready), 64'd1);
      check("full_post_match_count", 64'(dut.count_q), 64'd3);
      check("bp_data_0", 64'(wb_data), 64'h400_77);
      tick();
      net_valid = 1'b0;
      check("bp_data_1", 64'(wb_data), 64'h400_77);
      check("refill_count", 64'(dut.count_q), 64'd4);
      check("refill_e1_meta", 64'(dut.meta_q[1]), 64'h41);
      check("refill_e2_meta", 64'(dut.meta_q[2]), 64'h42);
      check("refill_e3_meta", 64'(dut.meta_q[3]), 64'h50);
      check("refill_e3_data", 64'(dut.data_q[3]), 64'h500);
      tick();
      check("bp_data_2", 64'(wb_data), 64'h400_77);
      check("bp_valid_2", 64'(wb_valid), 64'd1);
      drain();

      // Reset while waiting with entries buffered.
      do_reset();
      push_msg(32'h60, 32'h6);
      push_msg(32'h61, 32'h7);
      issue(1'b0, 32'h99, 32'hFFFF_FFFF, 8'hEE);
      tick();
      tick();
      check("pre_reset_wait", 64'(rq_ready), 64'd0);
      do_reset();
      check("midrst_rq_ready", 64'(rq_ready), 64'd1);
      check("midrst_net_ready", 64'(net_ready), 64'd1);
      check("midrst_wb_valid", 64'(wb_valid), 64'd0);
      check("midrst_wb_data", 64'(wb_data), 64'd0);
      check("midrst_count", 64'(dut.count_q), 64'd0);
      issue(1'b1, 32'h0, 32'h0, 8'h44);
      tick();
      check("midrst_buffer_empty", 64'(wb_data), 64'h0_44);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
